// File: rtl/instr_mem_loader_if.sv
// Load and fetch bus of the instruction memory loader. With IMEM_PARITY_EN
// defined, the bus also carries parity_err alongside fetch_valid.
interface instr_mem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  load_start;
  logic [ADDR_WIDTH-1:0] load_base;
  logic [ADDR_WIDTH:0]   load_len;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  load_done;
  logic                  busy;
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] fetch_data;
`ifdef IMEM_PARITY_EN
  logic                  parity_err;
`endif

  modport master (
    output load_start, load_base, load_len, load_valid, load_data,
    output fetch_req, fetch_addr,
    input  load_ready, load_done, busy, fetch_valid, fetch_data
`ifdef IMEM_PARITY_EN
   ,input  parity_err
`endif
  );

  modport slave (
    input  load_start, load_base, load_len, load_valid, load_data,
    input  fetch_req, fetch_addr,
    output load_ready, load_done, busy, fetch_valid, fetch_data
`ifdef IMEM_PARITY_EN
   ,output parity_err
`endif
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory with a burst loader (IDLE/LOAD) and a 1-cycle fetch port.
// Optional feature: IMEM_PARITY_EN adds a stored even-parity bit and parity_err.
module instr_mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_mem_loader_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  fvld_q, fvld_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
  logic                  wr_en;

  // Storage is deliberately unreset so a mid-burst reset keeps written words.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef IMEM_PARITY_EN
  logic                  mem_par [DEPTH];
  logic                  perr_q, perr_d;
`endif

  assign wr_en = (state_q == LOAD) && bus.load_valid;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    fvld_d  = 1'b0;
    fdata_d = fdata_q;
`ifdef IMEM_PARITY_EN
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          if (bus.load_len != '0) begin
            state_d = LOAD;
            wptr_d  = bus.load_base;
            cnt_d   = bus.load_len;
          end else begin
            done_d  = 1'b1;
          end
        end
        // No write happens in IDLE, so a concurrent fetch sees pre-load data.
        if (bus.fetch_req) begin
          fvld_d  = 1'b1;
          fdata_d = mem[bus.fetch_addr];
`ifdef IMEM_PARITY_EN
          perr_d  = (^mem[bus.fetch_addr]) != mem_par[bus.fetch_addr];
`endif
        end
      end
      LOAD: begin
        if (bus.load_valid) begin
          wptr_d = wptr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == (ADDR_WIDTH+1)'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fvld_q  <= 1'b0;
      fdata_q <= '0;
`ifdef IMEM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      fvld_q  <= fvld_d;
      fdata_q <= fdata_d;
`ifdef IMEM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_q] <= bus.load_data;
`ifdef IMEM_PARITY_EN
      mem_par[wptr_q] <= ^bus.load_data;
`endif
    end
  end

  assign bus.load_ready  = (state_q == LOAD);
  assign bus.busy        = (state_q == LOAD);
  assign bus.load_done   = done_q;
  assign bus.fetch_valid = fvld_q;
  assign bus.fetch_data  = fdata_q;
`ifdef IMEM_PARITY_EN
  assign bus.parity_err  = perr_q;
`endif
endmodule
